// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, buffers {pc, instr} pairs in a prefetch FIFO,
// and flushes on redirect. Optional perf counters are enabled with `define FETCH_PERF_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Fetch_en,
  output logic [31:0] Rom_addr,
  input  logic [31:0] Rom_data,
  input  logic        Redirect_valid,
  input  logic [31:0] Redirect_pc,
  output logic        Inst_valid,
  input  logic        Inst_ready,
  output logic [31:0] Inst_data,
  output logic [31:0] Inst_pc,
  output logic [31:0] Fetch_count,
  output logic [31:0] Stall_count
);

  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic [31:0]        pc_mem_d    [FIFO_DEPTH];
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        instr_mem_d [FIFO_DEPTH];

  logic empty, full, pop, push, redirect_ok;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^Redirect_pc[1:0];

  assign Rom_addr    = pc_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  // Head is hidden during a redirect so no handshake can complete on a stale entry.
  assign Inst_valid  = ~empty & ~Redirect_valid;
  assign pop         = Inst_valid & Inst_ready;
  assign redirect_ok = Redirect_valid & (state_q != BOOT);
  assign push        = (state_q == RUN) & Fetch_en & ~Redirect_valid & (~full | pop);

  assign Inst_data = empty ? NOP   : instr_mem_q[rd_ptr_q];
  assign Inst_pc   = empty ? '0    : pc_mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (!Fetch_en) state_d = HALT;
      HALT:    if (Fetch_en)  state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_ok) begin
      pc_d     = {Redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = pc_q;
        instr_mem_d[wr_ptr_q] = Rom_data;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        pc_d                  = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    fetch_cnt_d = push ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
    stall_cnt_d = (Inst_valid & ~Inst_ready) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Fetch_count = fetch_cnt_q;
  assign Stall_count = stall_cnt_q;
`else
  assign Fetch_count = 32'h0;
  assign Stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a small combinational ROM model.
module tb_fetch_sequencer;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .Fetch_en      (fetch_en),
    .Rom_addr      (rom_addr),
    .Rom_data      (rom_data),
    .Redirect_valid(redirect_valid),
    .Redirect_pc   (redirect_pc),
    .Inst_valid    (inst_valid),
    .Inst_ready    (inst_ready),
    .Inst_data     (inst_data),
    .Inst_pc       (inst_pc),
    .Fetch_count   (fetch_count),
    .Stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  return 32'hFE010113;
      32'h04:  return 32'h00112E23;
      32'h08:  return 32'h00812C23;
      32'h0C:  return 32'h02010413;
      32'h10:  return 32'h00050793;
      32'h14:  return 32'hFEF42623;
      32'h18:  return 32'hFEC42783;
      32'h1C:  return 32'h000F8713;
      32'h20:  return 32'h00E7A023;
      32'h40:  return 32'h00000793;
      32'h44:  return 32'hFCDFF06F;
      default: return 32'h00000013;
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the BOOT cycle right after reset release.
  task automatic do_reset(input logic rdy);
    rst = 1'b1; fetch_en = 1'b1; inst_ready = rdy;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h13) begin n_bad++; $display("FAIL rst_data: got %h expected 00000013", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h expected 00000000", inst_pc); end
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h expected 00000000", rom_addr); end
    n_cmp++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      n_bad++; $display("FAIL rst_cnt: got %h/%h expected 0/0", fetch_count, stall_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_fetch();
    do_reset(1'b1);
    #1;  // BOOT
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL t1_boot_valid: got %b expected 0", inst_valid); end
    step(); #1;  // first RUN cycle
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL t1_addr0: got %h expected 00000000", rom_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL t1_run_valid: got %b expected 0", inst_valid); end
    step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'hFE010113) begin
      n_bad++; $display("FAIL t1_head0: got v=%b pc=%h d=%h expected v=1 pc=00000000 d=FE010113", inst_valid, inst_pc, inst_data); end
    n_cmp++; if (rom_addr !== 32'h4) begin n_bad++; $display("FAIL t1_addr4: got %h expected 00000004", rom_addr); end
    step(); #1;
    n_cmp++; if (inst_pc !== 32'h4 || inst_data !== 32'h00112E23) begin
      n_bad++; $display("FAIL t1_head4: got pc=%h d=%h expected pc=00000004 d=00112E23", inst_pc, inst_data); end
    n_cmp++; if (fetch_count !== (PERF ? 32'd2 : 32'd0)) begin
      n_bad++; $display("FAIL t1_fcnt: got %0d expected %0d", fetch_count, PERF ? 2 : 0); end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h1E; #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL t2_redir_valid: got %b expected 0", inst_valid); end
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (rom_addr !== 32'h1C || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL t2_fetch: got addr=%h v=%b expected addr=0000001C v=0", rom_addr, inst_valid); end
    step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1C || inst_data !== 32'h000F8713) begin
      n_bad++; $display("FAIL t2_head: got v=%b pc=%h d=%h expected v=1 pc=0000001C d=000F8713", inst_valid, inst_pc, inst_data); end
    n_cmp++; if (fetch_count !== (PERF ? 32'd3 : 32'd0)) begin
      n_bad++; $display("FAIL t2_fcnt: got %0d expected %0d", fetch_count, PERF ? 3 : 0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    step(); step(); step();  // two pushes done, FIFO full
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (rom_addr !== 32'h8) begin n_bad++; $display("FAIL t3_hold%0d: got %h expected 00000008", i, rom_addr); end
      step();
    end
    inst_ready = 1'b1; #1;
    n_cmp++; if (stall_count !== (PERF ? 32'd4 : 32'd0)) begin
      n_bad++; $display("FAIL t3_stall: got %0d expected %0d", stall_count, PERF ? 4 : 0); end
    n_cmp++; if (fetch_count !== (PERF ? 32'd2 : 32'd0)) begin
      n_bad++; $display("FAIL t3_fcnt: got %0d expected %0d", fetch_count, PERF ? 2 : 0); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
        n_bad++; $display("FAIL t3_order%0d: got v=%b pc=%h expected v=1 pc=%h", i, inst_valid, inst_pc, exp_pc); end
      exp_pc = exp_pc + 32'd4;
      step(); #1;
    end
  endtask

  task automatic test_redirect_rom_edge(input logic [31:0] tgt, input logic [31:0] pc0, input logic [31:0] d0,
                                        input logic [31:0] pc1, input logic [31:0] d1);
    do_reset(1'b1);
    step(); step();
    redirect_valid = 1'b1; redirect_pc = tgt; #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_%h_valid: got %b expected 0", tgt, inst_valid); end
    step();
    redirect_valid = 1'b0;
    step(); #1;
    n_cmp++; if (inst_pc !== pc0 || inst_data !== d0) begin
      n_bad++; $display("FAIL rd_%h_first: got pc=%h d=%h expected pc=%h d=%h", tgt, inst_pc, inst_data, pc0, d0); end
    step(); #1;
    n_cmp++; if (inst_pc !== pc1 || inst_data !== d1) begin
      n_bad++; $display("FAIL rd_%h_second: got pc=%h d=%h expected pc=%h d=%h", tgt, inst_pc, inst_data, pc1, d1); end
  endtask

  task automatic test_boot_redirect();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (rom_addr !== 32'h0) begin n_bad++; $display("FAIL boot_redir: got %h expected 00000000", rom_addr); end
  endtask

  task automatic test_halt_and_reset();
    do_reset(1'b0);
    step(); step(); step();  // FIFO holds pcs 0 and 4
    fetch_en = 1'b0; inst_ready = 1'b1; #1;
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL t6_drain0: got %h expected 00000000", inst_pc); end
    step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      n_bad++; $display("FAIL t6_drain4: got v=%b pc=%h expected v=1 pc=00000004", inst_valid, inst_pc); end
    step(); step(); #1;
    n_cmp++; if (inst_valid !== 1'b0 || rom_addr !== 32'h8) begin
      n_bad++; $display("FAIL t6_empty: got v=%b addr=%h expected v=0 addr=00000008", inst_valid, rom_addr); end
    n_cmp++; if (fetch_count !== (PERF ? 32'd2 : 32'd0) || stall_count !== (PERF ? 32'd1 : 32'd0)) begin
      n_bad++; $display("FAIL t6_cnt: got %0d/%0d expected %0d/%0d", fetch_count, stall_count, PERF ? 2 : 0, PERF ? 1 : 0); end
    fetch_en = 1'b1;
    step(); step(); #1;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
      n_bad++; $display("FAIL t6_resume: got v=%b pc=%h expected v=1 pc=00000008", inst_valid, inst_pc); end
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0 || rom_addr !== 32'h0) begin
      n_bad++; $display("FAIL t6_rst: got v=%b addr=%h expected v=0 addr=00000000", inst_valid, rom_addr); end
    n_cmp++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      n_bad++; $display("FAIL t6_rst_cnt: got %0d/%0d expected 0/0", fetch_count, stall_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_redirect();
    test_backpressure();
    test_redirect_rom_edge(32'h44, 32'h44, 32'hFCDFF06F, 32'h48, 32'h00000013);
    test_redirect_rom_edge(32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000013, 32'h0, 32'hFE010113);
    test_boot_redirect();
    test_halt_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
